// File: rtl/jt51_so_pkg.sv
// Frame layout constants and lock-FSM encoding shared by the YM3012 serial receiver.
// Pure declarations; no logic, no latency, no flow control.
package jt51_so_pkg;
    localparam int FRAME_BITS = 16;
    localparam int MAN_LSB    = 3;
    localparam int MAN_W      = 10;
    localparam int EXP_LSB    = 13;
    localparam int EXP_W      = 3;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        GOT_L  = 2'd1,
        LOCKED = 2'd2
    } so_state_t;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/jt51_so_sync.sv
// Input synchroniser plus cen-qualified edge detect; level lags din by SYNC_STAGES clk.
// rise/fall are combinational and only valid on cen cycles; no backpressure.
module jt51_so_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            if (cen) prev <= level;
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = cen & level & ~prev;
    assign fall  = cen & ~level & prev;
endmodule

// File: rtl/jt51_so_rx.sv
// YM3012-style serial DAC receiver: deserialises SH1/SH2 framed SO bits into man/exp pairs.
// Outputs, sample and frame_err update 1 clk after the cen tick that sees a strobe fall; no backpressure.
module jt51_so_rx
    import jt51_so_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             so,
    input  logic             sh1,
    input  logic             sh2,
    output logic [MAN_W-1:0] left_man,
    output logic [EXP_W-1:0] left_exp,
    output logic [MAN_W-1:0] right_man,
    output logic [EXP_W-1:0] right_exp,
    output logic             sample,
    output logic             locked,
    output logic             frame_err
);
    localparam logic [1:0]       FLUSH_N = 2'(SYNC_STAGES);
    localparam logic [2:0]       LOCK_N  = 3'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0] GOOD_N  = CNT_W'(FRAME_BITS);

    logic so_lvl, sh1_lvl, sh2_lvl, sh1_fall, sh2_fall;
    logic so_rise_unused, so_fall_unused, sh1_rise_unused, sh2_rise_unused;

    jt51_so_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_so (
        .clk(clk), .rst(rst), .cen(cen), .din(so),
        .level(so_lvl), .rise(so_rise_unused), .fall(so_fall_unused)
    );
    jt51_so_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sh1 (
        .clk(clk), .rst(rst), .cen(cen), .din(sh1),
        .level(sh1_lvl), .rise(sh1_rise_unused), .fall(sh1_fall)
    );
    jt51_so_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sh2 (
        .clk(clk), .rst(rst), .cen(cen), .din(sh2),
        .level(sh2_lvl), .rise(sh2_rise_unused), .fall(sh2_fall)
    );

    logic [FRAME_BITS-1:0] sr;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            flush;
    logic                  armed, poison, want_r;
    logic [2:0]            lock_cnt, lock_nx;
    so_state_t             state, state_nx;
    logic                  want_r_nx, smp_nx;
    logic                  unused_bits;

    assign unused_bits = sr[0];

    // armed only after a cen tick with both strobes low, so a frame cut by reset is never counted
    logic tick, both, any, conflict_new, eof, good, good_l, good_r, bad;
    assign tick         = cen & armed;
    assign both         = sh1_lvl & sh2_lvl;
    assign any          = sh1_lvl | sh2_lvl;
    assign conflict_new = tick & both & ~poison;
    assign eof          = tick & (sh1_fall | sh2_fall) & ~poison;
    assign good         = eof & (cnt == GOOD_N);
    assign good_l       = good & sh1_fall;
    assign good_r       = good & sh2_fall;
    assign bad          = conflict_new | (eof & ~good);

    always_comb begin
        state_nx  = state;
        lock_nx   = lock_cnt;
        want_r_nx = want_r;
        smp_nx    = 1'b0;
        if (bad) begin
            state_nx  = HUNT;
            lock_nx   = '0;
            want_r_nx = 1'b0;
        end else if (good_l || good_r) begin
            case (state)
                HUNT: begin
                    if (good_l) state_nx = GOT_L;
                    else        lock_nx  = '0;
                end
                GOT_L: begin
                    if (good_r) begin
                        lock_nx = 3'(lock_cnt + 3'd1);
                        if (3'(lock_cnt + 3'd1) >= LOCK_N) begin
                            state_nx  = LOCKED;
                            want_r_nx = 1'b0;
                            smp_nx    = 1'b1;
                        end else begin
                            state_nx = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (good_l && !want_r) begin
                        want_r_nx = 1'b1;
                    end else if (good_r && want_r) begin
                        want_r_nx = 1'b0;
                        smp_nx    = 1'b1;
                    end else begin
                        state_nx  = HUNT;
                        lock_nx   = '0;
                        want_r_nx = 1'b0;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            cnt       <= '0;
            flush     <= '0;
            armed     <= 1'b0;
            poison    <= 1'b0;
            want_r    <= 1'b0;
            lock_cnt  <= '0;
            state     <= HUNT;
            left_man  <= '0;
            left_exp  <= '0;
            right_man <= '0;
            right_exp <= '0;
            sample    <= 1'b0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (flush != FLUSH_N) flush <= flush + 2'd1;
            if (cen && flush == FLUSH_N && !any) armed <= 1'b1;

            if (tick) begin
                if (any) sr <= {so_lvl, sr[FRAME_BITS-1:1]};
                // an overlap poisons everything until both strobes have gone low again
                if (both) begin
                    cnt    <= '0;
                    poison <= 1'b1;
                end else if (sh1_fall || sh2_fall) begin
                    cnt <= any ? CNT_W'(1) : '0;
                end else if (any) begin
                    cnt <= cnt_inc(cnt);
                end
                if (poison && !any) poison <= 1'b0;
            end

            if (good_l) begin
                left_man <= sr[MAN_LSB +: MAN_W];
                left_exp <= sr[EXP_LSB +: EXP_W];
            end
            if (good_r) begin
                right_man <= sr[MAN_LSB +: MAN_W];
                right_exp <= sr[EXP_LSB +: EXP_W];
            end

            state     <= state_nx;
            lock_cnt  <= lock_nx;
            want_r    <= want_r_nx;
            sample    <= smp_nx;
            frame_err <= bad;
            locked    <= (state_nx == LOCKED);
        end
    end
endmodule

// File: tb/tb_jt51_so_rx.sv
// Directed scoreboard bench for jt51_so_rx: stimulus queues expected output events, a monitor pops them.
module tb_jt51_so_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       so  = 1'b0;
    logic       sh1 = 1'b0;
    logic       sh2 = 1'b0;
    logic [9:0] left_man, right_man;
    logic [2:0] left_exp, right_exp;
    logic       sample, locked, frame_err;

    always #5 clk = ~clk;

    jt51_so_rx #(.SYNC_STAGES(2), .LOCK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .cen(cen), .so(so), .sh1(sh1), .sh2(sh2),
        .left_man(left_man), .left_exp(left_exp),
        .right_man(right_man), .right_exp(right_exp),
        .sample(sample), .locked(locked), .frame_err(frame_err)
    );

    typedef struct packed {
        logic       smp;
        logic       fe;
        logic       lk;
        logic [9:0] lm;
        logic [2:0] le;
        logic [9:0] rm;
        logic [2:0] re;
    } ev_t;

    localparam logic [15:0] WL  = {3'd5, 10'h155, 3'b011};
    localparam logic [15:0] WR  = {3'd7, 10'h2AA, 3'b110};
    localparam logic [15:0] WL2 = {3'd1, 10'h3FF, 3'b000};
    localparam logic [15:0] WS  = {3'd2, 10'h0F0, 3'b000};

    ev_t q[$];
    ev_t m = '0;
    ev_t cur;
    ev_t prev = '0;
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic expect_ev(input logic smp, input logic fe, input logic lk);
        ev_t e;
        m.lk  = lk;
        e     = m;
        e.smp = smp;
        e.fe  = fe;
        q.push_back(e);
    endtask

    // one serial bit period: 4 clk, cen high in the last one
    task automatic tick(input logic a, input logic b, input logic d);
        sh1 = a;
        sh2 = b;
        so  = d;
        cen = 1'b0;
        repeat (3) @(negedge clk);
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
    endtask

    task automatic send(input int ch, input int nbits, input logic [15:0] w);
        for (int i = 0; i < nbits; i++) tick(ch == 0, ch == 1, w[i % 16]);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pair();
        send(0, 16, WL);
        send(1, 16, WR);
    endtask

    always @(negedge clk) begin
        cur = {sample, frame_err, locked, left_man, left_exp, right_man, right_exp};
        if (!rst && (cur.smp || cur.fe || cur[26:0] != prev[26:0])) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got %h, expected no event at %0t", cur, $time);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("sample",    32'(cur.smp), 32'(e.smp));
                chk("frame_err", 32'(cur.fe),  32'(e.fe));
                chk("locked",    32'(cur.lk),  32'(e.lk));
                chk("left_man",  32'(cur.lm),  32'(e.lm));
                chk("left_exp",  32'(cur.le),  32'(e.le));
                chk("right_man", 32'(cur.rm),  32'(e.rm));
                chk("right_exp", 32'(cur.re),  32'(e.re));
            end
        end
        prev = cur;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // reset in the middle of a left frame; the remainder must be discarded
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, WL[i]);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 8; i < 16; i++) tick(1'b1, 1'b0, WL[i]);
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_left_man",  32'(left_man),  32'h0);
        chk("rst_left_exp",  32'(left_exp),  32'h0);
        chk("rst_right_man", 32'(right_man), 32'h0);
        chk("rst_right_exp", 32'(right_exp), 32'h0);
        chk("rst_locked",    32'(locked),    32'h0);
        chk("rst_sample",    32'(sample),    32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);

        // nominal: pair 1 latches but does not lock, pair 2 locks with sample
        m.lm = 10'h155; m.le = 3'd5;
        expect_ev(1'b0, 1'b0, 1'b0);
        send(0, 16, WL);
        m.rm = 10'h2AA; m.re = 3'd7;
        expect_ev(1'b0, 1'b0, 1'b0);
        send(1, 16, WR);
        send(0, 16, WL);
        expect_ev(1'b1, 1'b0, 1'b1);
        send(1, 16, WR);
        send(0, 16, WL);
        expect_ev(1'b1, 1'b0, 1'b1);
        send(1, 16, WR);

        // short left frame while locked
        expect_ev(1'b0, 1'b1, 1'b0);
        send(0, 15, WL2);
        pair();
        send(0, 16, WL);
        expect_ev(1'b1, 1'b0, 1'b1);
        send(1, 16, WR);

        // long right frame while locked
        expect_ev(1'b0, 1'b1, 1'b0);
        send(1, 17, WL2);
        pair();
        send(0, 16, WL);
        expect_ev(1'b1, 1'b0, 1'b1);
        send(1, 16, WR);

        // order error L, L, R: the second left is good, latches, and drops lock
        send(0, 16, WL);
        m.lm = 10'h3FF; m.le = 3'd1;
        expect_ev(1'b0, 1'b0, 1'b0);
        send(0, 16, WL2);
        send(1, 16, WR);
        m.lm = 10'h155; m.le = 3'd5;
        expect_ev(1'b0, 1'b0, 1'b0);
        pair();
        send(0, 16, WL);
        expect_ev(1'b1, 1'b0, 1'b1);
        send(1, 16, WR);

        // long cen-free stretch: lock must hold
        repeat (200) @(negedge clk);

        // overlap: sh2 high for one tick inside a left frame
        expect_ev(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) tick(1'b1, i == 5, WL2[i]);
        tick(1'b0, 1'b0, 1'b0);

        // 48-bit strobe: a wrapping counter would read 16 and latch
        expect_ev(1'b0, 1'b1, 1'b0);
        send(1, 48, WS);

        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("pending_events", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
